// File: rtl/sat_cmd_issuer_if.sv
// Host/accelerator-side bundle for the SAT command issuer.
// slave = issuer view, master = host/bench view.
interface sat_cmd_issuer_if #(
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_cmd;
  logic          flush;
  logic [7:0]    cmd_out;
  logic          cmd_issue;
  logic          sat_res_in;
  logic          res_valid;
  logic          res_value;
  logic [7:0]    res_index;
  logic [AW:0]   fifo_count;
  logic          underrun;

  modport slave (
    input  in_valid, in_cmd, flush, sat_res_in,
    output in_ready, cmd_out, cmd_issue, res_valid, res_value, res_index,
           fifo_count, underrun
  );

  modport master (
    output in_valid, in_cmd, flush, sat_res_in,
    input  in_ready, cmd_out, cmd_issue, res_valid, res_value, res_index,
           fifo_count, underrun
  );
endinterface

// File: rtl/sat_cmd_issuer.sv
// SAT accelerator command front-end: host command FIFO, RESET preamble,
// one-per-cycle issue and indexed capture of the result after each CNF command.
module sat_cmd_issuer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned INIT_CYC = 4,
  parameter int unsigned RES_LAT  = 2,
  parameter logic [7:0]  FILL_CMD = 8'hC0
) (
  input  logic             clk,
  input  logic             reset,
  sat_cmd_issuer_if.slave  bus
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int unsigned RW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
  localparam logic [1:0]  ST_CLAUSE = 2'b01;
  localparam logic [1:0]  ST_CNF    = 2'b10;

  typedef enum logic [1:0] {INIT, ISSUE, WAIT_RES} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [RW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    cmd_out_q, cmd_out_d;
  logic          cmd_issue_q, cmd_issue_d;
  logic          res_valid_q, res_valid_d;
  logic          res_value_q, res_value_d;
  logic [7:0]    res_index_q, res_index_d;
  logic          underrun_q, underrun_d;
  logic          clause_open_q, clause_open_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic          in_ready_c;
  logic          push_c;
  logic          pop_c;
  logic [7:0]    head_c;

  assign in_ready_c = (count_q < CW'(DEPTH));
  assign push_c     = bus.in_valid && in_ready_c && !bus.flush;
  assign head_c     = mem_q[rd_ptr_q];

  // Issue FSM plus FIFO pointer/count bookkeeping; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_out_d     = cmd_out_q;
    cmd_issue_d   = 1'b0;
    res_valid_d   = 1'b0;
    res_value_d   = res_value_q;
    res_index_d   = res_index_q + 8'(res_valid_q);
    underrun_d    = underrun_q;
    clause_open_d = clause_open_q;
    pop_c         = 1'b0;

    case (state_q)
      INIT: begin
        cmd_out_d     = 8'h00;
        clause_open_d = 1'b0;
        if (init_cnt_q == IW'(INIT_CYC - 1)) begin
          state_d    = ISSUE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      ISSUE: begin
        if (count_q != '0) begin
          pop_c         = 1'b1;
          cmd_out_d     = head_c;
          cmd_issue_d   = 1'b1;
          clause_open_d = (head_c[7:6] == ST_CLAUSE);
          if (head_c[7:6] == ST_CNF) begin
            state_d    = WAIT_RES;
            wait_cnt_d = '0;
          end
        end else begin
          cmd_out_d = FILL_CMD;
          if (clause_open_q) begin
            underrun_d = 1'b1;
          end
        end
      end
      WAIT_RES: begin
        if (wait_cnt_q == RW'(RES_LAT - 1)) begin
          res_valid_d = 1'b1;
          res_value_d = bus.sat_res_in;
          state_d     = ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + RW'(1);
        end
      end
      default: state_d = INIT;
    endcase

    if (bus.flush) begin
      state_d       = INIT;
      init_cnt_d    = '0;
      wait_cnt_d    = '0;
      cmd_out_d     = 8'h00;
      cmd_issue_d   = 1'b0;
      res_valid_d   = 1'b0;
      res_value_d   = res_value_q;
      clause_open_d = 1'b0;
      pop_c         = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + AW'(push_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      cmd_out_q     <= 8'h00;
      cmd_issue_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_value_q   <= 1'b0;
      res_index_q   <= 8'h00;
      underrun_q    <= 1'b0;
      clause_open_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      cmd_out_q     <= cmd_out_d;
      cmd_issue_q   <= cmd_issue_d;
      res_valid_q   <= res_valid_d;
      res_value_q   <= res_value_d;
      res_index_q   <= res_index_d;
      underrun_q    <= underrun_d;
      clause_open_q <= clause_open_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage array carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= bus.in_cmd;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.fifo_count = count_q;
  assign bus.cmd_out    = cmd_out_q;
  assign bus.cmd_issue  = cmd_issue_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_value  = res_value_q;
  assign bus.res_index  = res_index_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_sat_cmd_issuer.sv
// Scoreboard bench for sat_cmd_issuer: expected commands/results are queued on
// push and retired when the issuer reports them.
module tb_sat_cmd_issuer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sat_cmd_issuer_if #(.AW(4)) bus ();

  sat_cmd_issuer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_chk;
  int         n_fail;
  int         cyc;
  int         count_m;
  int         exp_idx;
  int         res_seen;
  bit         drop_sat_after_first;
  logic [7:0] exp_q [$];
  int         res_due_q [$];
  logic       res_vals [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: model the edge from pre-edge inputs, then compare just after it.
  task automatic tick();
    logic       pv, pf, ps, acc;
    logic [7:0] pc, e;
    int         d;
    pv  = bus.in_valid;
    pc  = bus.in_cmd;
    pf  = bus.flush;
    ps  = bus.sat_res_in;
    acc = pv && (count_m < 16) && !pf;
    @(posedge clk);
    #1;
    cyc++;
    if (pf) begin
      check("flush_issue", bus.cmd_issue, 0);
      check("flush_res_valid", bus.res_valid, 0);
      exp_q.delete();
      res_due_q.delete();
      count_m = 0;
    end else begin
      if (bus.cmd_issue) begin
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_out", bus.cmd_out, e);
          if (e[7:6] == 2'b10) res_due_q.push_back(cyc + 2);
          count_m--;
        end
      end
      if (acc) begin
        exp_q.push_back(pc);
        count_m++;
      end
      if (bus.res_valid) begin
        if (res_due_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          d = res_due_q.pop_front();
          check("res_time", cyc, d);
          check("res_value", bus.res_value, ps);
          check("res_index", bus.res_index, exp_idx);
          exp_idx = (exp_idx + 1) % 256;
          if (res_seen < 8) res_vals[res_seen] = bus.res_value;
          res_seen++;
          if (drop_sat_after_first && res_seen == 1) bus.sat_res_in = 1'b0;
        end
      end else if (res_due_q.size() != 0 && res_due_q[0] <= cyc) begin
        check("res_missing", 0, 1);
        void'(res_due_q.pop_front());
      end
    end
    check("fifo_count", bus.fifo_count, count_m);
    check("in_ready", bus.in_ready, (count_m < 16));
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    exp_q.delete();
    res_due_q.delete();
    count_m = 0;
    exp_idx = 0;
    check("rst_cmd_out", bus.cmd_out, 8'h00);
    check("rst_cmd_issue", bus.cmd_issue, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_value", bus.res_value, 0);
    check("rst_res_index", bus.res_index, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Four RESET commands, then the fill command on an empty FIFO.
  task automatic chk_preamble();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("pre_cmd_out", bus.cmd_out, 8'h00);
      check("pre_cmd_issue", bus.cmd_issue, 0);
    end
    tick();
    check("pre_fill_cmd", bus.cmd_out, 8'hC0);
    check("pre_fill_issue", bus.cmd_issue, 0);
  endtask

  task automatic push(input logic [7:0] c);
    bit ok;
    int k;
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    for (k = 0; k < 100; k++) begin
      ok = (count_m < 16);
      tick();
      if (ok) break;
    end
    if (k == 100) check("push_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && res_due_q.size() == 0) break;
      tick();
    end
    if (k == 300) check("drain_timeout", 0, 1);
    repeat (2) tick();
  endtask

  logic [7:0] burst [8];

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; count_m = 0; exp_idx = 0; res_seen = 0;
    drop_sat_after_first = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_cmd = 8'h00; bus.flush = 1'b0; bus.sat_res_in = 1'b1;
    burst = '{8'h40, 8'h42, 8'h80, 8'hC0, 8'h41, 8'h42, 8'h80, 8'hC0};

    // Reset release and preamble
    do_reset();
    chk_preamble();

    // Two-CNF burst, SAT=1 throughout
    foreach (burst[i]) push(burst[i]);
    drain();
    check("t2_res_count", res_seen, 2);
    check("t2_res0", res_vals[0], 1);
    check("t2_res1", res_vals[1], 1);
    check("t2_underrun", bus.underrun, 0);

    // Same burst, SAT drops to 0 before the second CNF sample
    res_seen = 0;
    drop_sat_after_first = 1'b1;
    foreach (burst[i]) push(burst[i]);
    drain();
    drop_sat_after_first = 1'b0;
    bus.sat_res_in = 1'b1;
    check("t3_res_count", res_seen, 2);
    check("t3_res0", res_vals[0], 1);
    check("t3_res1", res_vals[1], 0);

    // Fill the FIFO with CNF commands until it reports full
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_cmd   = 8'h80;
    for (int i = 0; i < 80 && count_m != 16; i++) tick();
    check("t4_reached_full", count_m, 16);
    check("t4_full_ready", bus.in_ready, 0);
    check("t4_full_count", bus.fifo_count, 16);
    tick();
    bus.in_valid = 1'b0;
    drain();
    check("t4_underrun", bus.underrun, 0);

    // Open clause left dangling -> sticky underrun
    push(8'h40);
    repeat (6) tick();
    check("t5_underrun", bus.underrun, 1);
    check("t5_fill_cmd", bus.cmd_out, 8'hC0);
    check("t5_fill_issue", bus.cmd_issue, 0);
    push(8'h80);
    drain();
    check("t5_underrun_sticky", bus.underrun, 1);

    // Flush on the result-sampling edge of a pending CNF
    push(8'h80);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk_preamble();
    check("t6_underrun_kept", bus.underrun, 1);
    push(8'h80);
    drain();

    // Reset asserted mid-stream
    push(8'h40); push(8'h42); push(8'h80); push(8'hC0);
    tick();
    do_reset();
    chk_preamble();
    push(8'h80);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
